// File: rtl/alu_pkg.sv
// Shared widths and FSM state encoding for the 4-bit ALU arbiter and its ALU.
package alu_pkg;

    localparam int ALU_DW  = 4;
    localparam int ALU_OPW = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_4_bit.sv
// Combinational 4-bit ALU; result wraps at 4 bits, no carry out.
module alu_4_bit
    import alu_pkg::*;
(
    input  logic [ALU_DW-1:0]  a,
    input  logic [ALU_DW-1:0]  b,
    input  logic [ALU_OPW-1:0] op,
    output logic [ALU_DW-1:0]  y
);

    always_comb begin
        y = '0;
        case (op)
            3'd0: y = a + b;
            3'd1: y = a - b;
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            3'd5: y = ~a;
            3'd6: y = a << 1;
            3'd7: y = a >> 1;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_4_bit_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping NREQ-1 -> 0.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_vld
);

    int          pos;
    logic [IDW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        pos       = 0;
        idx       = '0;
        for (int i = 0; i < NREQ; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NREQ) pos = pos - NREQ;
            idx = IDW'(pos);
            if (!grant_vld && req[idx]) begin
                grant_vld  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/alu_4_bit_arbiter.sv
// Shares one alu_4_bit between NREQ requesters, one op in flight, IDLE -> EXEC -> RESP.
// Optional ALU_ARB_ZERO_FLAG_EN adds a registered res_zero output.
module alu_4_bit_arbiter
    import alu_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [ALU_DW*NREQ-1:0]    req_a,
    input  logic [ALU_DW*NREQ-1:0]    req_b,
    input  logic [ALU_OPW*NREQ-1:0]   req_op,
    output logic [NREQ-1:0]           req_ready,
    output logic                      res_valid,
    output logic [ALU_DW-1:0]         res_data,
    output logic [IDW-1:0]            res_id,
    input  logic                      res_ready,
    output logic                      busy
`ifdef ALU_ARB_ZERO_FLAG_EN
    ,
    output logic                      res_zero
`endif
);

    logic [NREQ-1:0][ALU_DW-1:0]  a_lane, b_lane;
    logic [NREQ-1:0][ALU_OPW-1:0] op_lane;

    assign a_lane  = req_a;
    assign b_lane  = req_b;
    assign op_lane = req_op;

    state_t              state_q, state_d;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ALU_DW-1:0]   a_q, a_d, b_q, b_d;
    logic [ALU_OPW-1:0]  op_q, op_d;
    logic [IDW-1:0]      id_q, id_d;
    logic                res_valid_q, res_valid_d;
    logic [ALU_DW-1:0]   res_data_q, res_data_d;
    logic [IDW-1:0]      res_id_q, res_id_d;
`ifdef ALU_ARB_ZERO_FLAG_EN
    logic                res_zero_q, res_zero_d;
`endif

    logic [NREQ-1:0]     grant;
    logic [IDW-1:0]      grant_idx;
    logic                grant_vld;
    logic [ALU_DW-1:0]   alu_y;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    alu_4_bit u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (alu_y)
    );

    // Grant is only offered in IDLE and is masked during the reset cycle.
    assign req_ready = (state_q == S_IDLE && !rst) ? grant : '0;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        id_d        = id_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
`ifdef ALU_ARB_ZERO_FLAG_EN
        res_zero_d  = res_zero_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    a_d      = a_lane[grant_idx];
                    b_d      = b_lane[grant_idx];
                    op_d     = op_lane[grant_idx];
                    id_d     = grant_idx;
                    rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                res_data_d  = alu_y;
                res_id_d    = id_q;
                res_valid_d = 1'b1;
`ifdef ALU_ARB_ZERO_FLAG_EN
                res_zero_d  = (alu_y == '0);
`endif
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            id_q        <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
`ifdef ALU_ARB_ZERO_FLAG_EN
            res_zero_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            id_q        <= id_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
`ifdef ALU_ARB_ZERO_FLAG_EN
            res_zero_q  <= res_zero_d;
`endif
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != S_IDLE);
`ifdef ALU_ARB_ZERO_FLAG_EN
    assign res_zero  = res_zero_q;
`endif

endmodule
